// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the phase scheduler and its environment.
// Preemption signals exist only when PHASE_PREEMPT_EN is defined.
interface traffic_phase_scheduler_if;
    logic        tick;
    logic [3:0]  req;
    logic [11:0] lights;
    logic [1:0]  phase;
    logic        cycle_pulse;
`ifdef PHASE_PREEMPT_EN
    logic        preempt;
    logic [1:0]  preempt_phase;

    modport master (output tick, req, preempt, preempt_phase,
                    input  lights, phase, cycle_pulse);
    modport slave  (input  tick, req, preempt, preempt_phase,
                    output lights, phase, cycle_pulse);
`else
    modport master (output tick, req,
                    input  lights, phase, cycle_pulse);
    modport slave  (input  tick, req,
                    output lights, phase, cycle_pulse);
`endif
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven round-robin phase scheduler with min/max green, yellow and all-red.
// Optional emergency preemption is enabled by defining PHASE_PREEMPT_EN.
module traffic_phase_scheduler #(
    parameter int unsigned GREEN_MIN = 5,
    parameter int unsigned GREEN_MAX = 15,
    parameter int unsigned YELLOW    = 2,
    parameter int unsigned ALLRED    = 1,
    parameter int unsigned CW        = 5
) (
    input logic                        clk,
    input logic                        rst,
    traffic_phase_scheduler_if.slave   bus
);

    localparam int unsigned    CIW        = CW + 1;
    localparam logic [CIW-1:0] LP_GMIN    = CIW'(GREEN_MIN);
    localparam logic [CIW-1:0] LP_GMAX    = CIW'(GREEN_MAX);
    localparam logic [CIW-1:0] LP_YEL_T   = CIW'(YELLOW);
    localparam logic [CIW-1:0] LP_AR_T    = CIW'(ALLRED);
    localparam logic [11:0]    LP_ALL_RED = 12'b100_100_100_100;
    localparam logic [2:0]     LP_YEL     = 3'b010;
    localparam logic [2:0]     LP_GRN     = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GREEN,
        ST_YELLOW,
        ST_ALLRED
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_phase;
    logic [11:0]    r_lights;
    logic           r_cycle_pulse;

    logic [CIW-1:0] w_cnt_inc;
    logic [CW-1:0]  w_cnt_sat;
    logic [3:0]     w_own;
    logic           w_conflict;
    logic           w_min_met;
    logic           w_max_met;
    logic           w_normal_exit;
    logic           w_yel_done;
    logic           w_ar_done;
    logic [1:0]     w_rr;
    logic           w_gn_exit;
    logic           w_grant;
    logic [1:0]     w_grant_phase;

    // All-red with a single approach set to the given lamp colour.
    function automatic logic [11:0] lamp(input logic [1:0] p, input logic [2:0] c);
        logic [11:0] l;
        l = LP_ALL_RED;
        case (p)
            2'd0:    l[2:0]  = c;
            2'd1:    l[5:3]  = c;
            2'd2:    l[8:6]  = c;
            default: l[11:9] = c;
        endcase
        return l;
    endfunction

    // Search cur+1, cur+2, cur+3, cur; first requester wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] cur, input logic [3:0] rq);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = cur;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + 2'(k);
            if (!found && rq[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_cnt_inc     = CIW'(r_cnt) + CIW'(1);
    assign w_min_met     = (w_cnt_inc >= LP_GMIN);
    assign w_max_met     = (w_cnt_inc >= LP_GMAX);
    assign w_cnt_sat     = w_max_met ? CW'(GREEN_MAX) : w_cnt_inc[CW-1:0];
    assign w_own         = 4'b0001 << r_phase;
    assign w_conflict    = |(bus.req & ~w_own);
    assign w_normal_exit = w_min_met && w_conflict && (!bus.req[r_phase] || w_max_met);
    assign w_yel_done    = (w_cnt_inc == LP_YEL_T);
    assign w_ar_done     = (w_cnt_inc == LP_AR_T);
    assign w_rr          = rr_pick(r_phase, bus.req);

`ifdef PHASE_PREEMPT_EN
    // Preemption overrides min green and pins green on the preempted phase.
    assign w_gn_exit     = bus.preempt ? (r_phase != bus.preempt_phase) : w_normal_exit;
    assign w_grant       = bus.preempt | (|bus.req);
    assign w_grant_phase = bus.preempt ? bus.preempt_phase : w_rr;
`else
    assign w_gn_exit     = w_normal_exit;
    assign w_grant       = |bus.req;
    assign w_grant_phase = w_rr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_phase       <= 2'd3;
            r_lights      <= LP_ALL_RED;
            r_cycle_pulse <= 1'b0;
        end else begin
            r_cycle_pulse <= 1'b0;
            if (bus.tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_grant) begin
                            r_state       <= ST_GREEN;
                            r_cnt         <= '0;
                            r_phase       <= w_grant_phase;
                            r_lights      <= lamp(w_grant_phase, LP_GRN);
                            r_cycle_pulse <= 1'b1;
                        end
                    end
                    ST_GREEN: begin
                        if (w_gn_exit) begin
                            r_state  <= ST_YELLOW;
                            r_cnt    <= '0;
                            r_lights <= lamp(r_phase, LP_YEL);
                        end else begin
                            r_cnt <= w_cnt_sat;
                        end
                    end
                    ST_YELLOW: begin
                        if (w_yel_done) begin
                            r_state  <= ST_ALLRED;
                            r_cnt    <= '0;
                            r_lights <= LP_ALL_RED;
                        end else begin
                            r_cnt <= w_cnt_inc[CW-1:0];
                        end
                    end
                    ST_ALLRED: begin
                        if (w_ar_done) begin
                            r_cnt <= '0;
                            if (w_grant) begin
                                r_state       <= ST_GREEN;
                                r_phase       <= w_grant_phase;
                                r_lights      <= lamp(w_grant_phase, LP_GRN);
                                r_cycle_pulse <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc[CW-1:0];
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= '0;
                        r_lights <= LP_ALL_RED;
                    end
                endcase
            end
        end
    end

    assign bus.lights      = r_lights;
    assign bus.phase       = r_phase;
    assign bus.cycle_pulse = r_cycle_pulse;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with hand-computed lamp patterns.
// The preemption scenario runs only when PHASE_PREEMPT_EN is defined.
module tb_traffic_phase_scheduler;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // Expected lamp words: green and yellow per phase, everything else red.
    logic [11:0] green_l  [4] = '{12'h921, 12'h90C, 12'h864, 12'h324};
    logic [11:0] yellow_l [4] = '{12'h922, 12'h914, 12'h8A4, 12'h524};
    localparam logic [11:0] ALL_RED = 12'h924;

    always #5 clk = ~clk;

    traffic_phase_scheduler_if ifc ();

    traffic_phase_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One-clock tick; returns at the following falling edge for sampling.
    task automatic do_tick();
        @(negedge clk) ifc.tick = 1'b1;
        @(negedge clk) ifc.tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) do_tick();
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        ifc.tick = 1'b0;
        ifc.req  = 4'b0000;
`ifdef PHASE_PREEMPT_EN
        ifc.preempt       = 1'b0;
        ifc.preempt_phase = 2'd0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_lights", 32'(ifc.lights), 32'(ALL_RED));
        check("rst_phase", 32'(ifc.phase), 32'd3);
        check("rst_pulse", 32'(ifc.cycle_pulse), 32'd0);
        rst = 1'b0;

        // No demand: stay all red
        for (int i = 0; i < 20; i++) begin
            do_tick();
            check("idle_lights", 32'(ifc.lights), 32'(ALL_RED));
            check("idle_pulse", 32'(ifc.cycle_pulse), 32'd0);
        end
        check("idle_phase", 32'(ifc.phase), 32'd3);

        // Single requester: green M1 then rest
        ifc.req = 4'b0001;
        do_tick();
        check("m1_green", 32'(ifc.lights), 32'(green_l[0]));
        check("m1_phase", 32'(ifc.phase), 32'd0);
        check("m1_pulse", 32'(ifc.cycle_pulse), 32'd1);
        @(negedge clk);
        check("m1_pulse_once", 32'(ifc.cycle_pulse), 32'd0);
        for (int i = 0; i < 30; i++) begin
            do_tick();
            check("m1_rest", 32'(ifc.lights), 32'(green_l[0]));
        end

        // Gap-out at minimum green, then S served
        do_reset();
        ifc.req = 4'b0001;
        do_tick();
        check("gap_green", 32'(ifc.lights), 32'(green_l[0]));
        do_tick();
        ifc.req = 4'b1000;
        ticks(3);
        check("gap_min_hold", 32'(ifc.lights), 32'(green_l[0]));
        do_tick();
        check("gap_yellow1", 32'(ifc.lights), 32'(yellow_l[0]));
        do_tick();
        check("gap_yellow2", 32'(ifc.lights), 32'(yellow_l[0]));
        do_tick();
        check("gap_allred", 32'(ifc.lights), 32'(ALL_RED));
        do_tick();
        check("gap_s_green", 32'(ifc.lights), 32'(green_l[3]));
        check("gap_s_phase", 32'(ifc.phase), 32'd3);
        check("gap_s_pulse", 32'(ifc.cycle_pulse), 32'd1);

        // Full demand: max-out rotation M1, M2, MT, S, M1
        do_reset();
        ifc.req = 4'b1111;
        do_tick();
        check("rr_first", 32'(ifc.lights), 32'(green_l[0]));
        for (int p = 0; p < 4; p++) begin
            ticks(14);
            check("rr_green_hold", 32'(ifc.lights), 32'(green_l[p]));
            check("rr_phase", 32'(ifc.phase), 32'(p));
            do_tick();
            check("rr_yellow1", 32'(ifc.lights), 32'(yellow_l[p]));
            do_tick();
            check("rr_yellow2", 32'(ifc.lights), 32'(yellow_l[p]));
            do_tick();
            check("rr_allred", 32'(ifc.lights), 32'(ALL_RED));
            do_tick();
            check("rr_next_green", 32'(ifc.lights), 32'(green_l[(p + 1) % 4]));
            check("rr_next_pulse", 32'(ifc.cycle_pulse), 32'd1);
        end

        // Asynchronous reset during M2 yellow
        do_reset();
        ifc.req = 4'b0010;
        do_tick();
        check("ar_m2_green", 32'(ifc.lights), 32'(green_l[1]));
        check("ar_m2_phase", 32'(ifc.phase), 32'd1);
        ifc.req = 4'b0001;
        ticks(4);
        check("ar_m2_hold", 32'(ifc.lights), 32'(green_l[1]));
        do_tick();
        check("ar_m2_yellow", 32'(ifc.lights), 32'(yellow_l[1]));
        #2 rst = 1'b1;
        #1;
        check("ar_lights", 32'(ifc.lights), 32'(ALL_RED));
        check("ar_phase", 32'(ifc.phase), 32'd3);
        check("ar_pulse", 32'(ifc.cycle_pulse), 32'd0);
        @(negedge clk) rst = 1'b0;
        ifc.req = 4'b0011;
        do_tick();
        check("ar_regrant", 32'(ifc.lights), 32'(green_l[0]));
        check("ar_regrant_phase", 32'(ifc.phase), 32'd0);

`ifdef PHASE_PREEMPT_EN
        // Preempt M1 in favour of MT, hold, then release
        do_reset();
        ifc.req = 4'b0001;
        do_tick();
        do_tick();
        ifc.preempt       = 1'b1;
        ifc.preempt_phase = 2'd2;
        do_tick();
        check("pe_yellow", 32'(ifc.lights), 32'(yellow_l[0]));
        ticks(2);
        check("pe_allred", 32'(ifc.lights), 32'(ALL_RED));
        do_tick();
        check("pe_mt_green", 32'(ifc.lights), 32'(green_l[2]));
        check("pe_mt_phase", 32'(ifc.phase), 32'd2);
        ticks(20);
        check("pe_mt_hold", 32'(ifc.lights), 32'(green_l[2]));
        ifc.preempt = 1'b0;
        do_tick();
        check("pe_release", 32'(ifc.lights), 32'(yellow_l[2]));
        ticks(3);
        check("pe_back_m1", 32'(ifc.lights), 32'(green_l[0]));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Demand-driven phase scheduler for a four-approach intersection. It arbitrates green time round-robin between approach detectors (M1, M2, MT, S) and enforces minimum green, maximum green, yellow and all-red clearance intervals. It drives one 3-bit lamp group per approach. It sits above the fixed-cycle light controller and replaces fixed timing with request-based sequencing, using the same lamp encoding: red 3'b100, yellow 3'b010, green 3'b001.

## Interface
- GREEN_MIN, 5: minimum green, in ticks (≥1)
- GREEN_MAX, 15: maximum green under conflicting demand, in ticks (≥GREEN_MIN)
- YELLOW, 2: yellow interval, in ticks (≥1)
- ALLRED, 1: all-red clearance, in ticks (≥1)
- CW, 5: tick counter width; must hold GREEN_MAX
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-cycle timebase strobe (nominally 1 s); all interval timing advances only on tick
- req  in  4  level demand per phase; bit0 M1, bit1 M2, bit2 MT, bit3 S
- lights  out  12  lamp groups; phase i at [3i+2:3i]
- phase  out  2  index of the phase currently green or yellow (last served phase when idle)
- cycle_pulse  out  1  one-clock pulse on entry to GREEN
- preempt  in  1  emergency preemption request (only with PHASE_PREEMPT_EN)
- preempt_phase  in  2  phase to serve under preemption (only with PHASE_PREEMPT_EN)

## Operation
- States: IDLE (all red, no service), GREEN, YELLOW, ALLRED. A registered tick counter `cnt` clears on every state change.
- Reset: state IDLE, cnt 0, phase 3, so the first search starts at phase 0. lights = 12'b100_100_100_100, cycle_pulse 0.
- IDLE: on a tick with any req bit set, select the phase by round-robin and go to GREEN.
- Round-robin: search phase+1, phase+2, phase+3, phase (mod 4); the first set bit wins.
- GREEN: lamp of `phase` is 001; all others are 100.
  - On each tick, cnt increments and saturates at GREEN_MAX.
  - "Conflict" means any req bit other than `phase` is set.
  - Exit to YELLOW on a tick where cnt+1 ≥ GREEN_MIN, conflict is set, and either req[phase]=0 (gap-out) or cnt+1 ≥ GREEN_MAX (max-out).
  - Without conflict, green rests indefinitely.
- YELLOW: lamp of `phase` is 010. Go to ALLRED on the tick where cnt+1 = YELLOW.
- ALLRED: all lamps are 100. On the tick where cnt+1 = ALLRED:
  - Select the next phase by round-robin and go to GREEN. This may reselect the same phase if it is the only requester.
  - If req = 0, go to IDLE.
- req is sampled only on tick cycles. Non-tick cycles hold all state.
- lights, phase and cycle_pulse are decoded from registered state only. Lamp outputs never show two non-red approaches.

## Timing
- Transitions occur on the clk edge of the qualifying tick cycle. Outputs reflect the new state on the cycle after that edge.
- Minimum service time for a phase is GREEN_MIN + YELLOW + ALLRED ticks.
- Wait bound for a continuously requesting phase is 3×(GREEN_MAX+YELLOW+ALLRED) ticks.
- cycle_pulse is high for exactly one clk, the first cycle GREEN is visible.
- tick held high continuously is legal: every clk then counts as one tick.
- rst asserted mid-interval forces IDLE and all-red immediately (asynchronous), with no yellow.

## Configuration
- PHASE_PREEMPT_EN defined: the preempt and preempt_phase ports exist.
  - On a tick with preempt=1 in GREEN with phase ≠ preempt_phase, go to YELLOW immediately, ignoring GREEN_MIN.
  - YELLOW and ALLRED run at full length.
  - ALLRED exit selects preempt_phase instead of round-robin.
  - While preempt=1, GREEN on preempt_phase never exits.
  - From IDLE, preempt selects preempt_phase.
  - On release, normal rules resume and the round-robin pointer equals preempt_phase.
- PHASE_PREEMPT_EN undefined: the ports are absent and the block behaves as described above with no preemption logic.

## Test plan
- Reset, then req=0 for 20 ticks → lights stay 12'h924 (all red), phase=3, no cycle_pulse.
- req=4'b0001 held → GREEN M1 after the first tick (lights[2:0]=001), rests green for 30 ticks, no yellow.
- Green M1 from req=4'b0001; assert req[3] at tick 2 → M1 holds to tick 5 (GREEN_MIN), yellow 2 ticks, all-red 1 tick, then S green.
- req=4'b1111 held → service order M1, M2, MT, S, M1; each green lasts exactly 15 ticks (max-out).
- Green on M2; pulse rst mid-yellow → all lamps red in the same cycle, state IDLE, next grant starts the search at phase 0.
- PHASE_PREEMPT_EN, green M1 at cnt=1, preempt=1 with preempt_phase=2 → M1 yellow next tick, after 3 ticks MT green, held until preempt drops.
